bsg_nonsynth_mem_mp_sync_mask_write_byte_pipe: RTL and testbench

Simulation-only, multi-port, byte-masked synchronous memory. Each of ports_p independent 1rw ports issues one request per cycle. Read data returns after a parameterised, fixed latency with a valid strobe. A built-in post-reset fill engine writes a pattern into every word. Used as a DRAM/backing-store stand-in for multi-channel testbenches that need deterministic read latency and a known memory image.

---
 rtl/bsg_nonsynth_mem_mp_pkg.sv | 16 +
 rtl/bsg_nonsynth_mem_read_pipe.sv | 44 ++++
 rtl/bsg_nonsynth_mem_mp_sync_mask_write_byte_pipe.sv | 157 +++++++++++++++
 tb/tb_bsg_nonsynth_mem_mp_sync_mask_write_byte_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_nonsynth_mem_mp_pkg.sv
// Shared types and constants for the multi-port byte-masked simulation memory.
package bsg_nonsynth_mem_mp_pkg;

  // Post-reset fill engine states.
  typedef enum logic [1:0] {
    e_idle,
    e_fill,
    e_done
  } fill_state_e;

  // Fill pattern selectors for init_mode_p.
  localparam int unsigned e_init_zero = 0;
  localparam int unsigned e_init_addr = 1;
  localparam int unsigned e_init_none = 2;

endpackage

// File: rtl/bsg_nonsynth_mem_read_pipe.sv
// Fixed-latency read-data pipeline for one port. Data stages only advance
// alongside a valid, so the last stage holds the most recent read result.
module bsg_nonsynth_mem_read_pipe #(
  parameter int unsigned width_p   = 32,
  parameter int unsigned latency_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic [latency_p-1:0]              v_q, v_d;
  logic [latency_p-1:0][width_p-1:0] data_q, data_d;

  // Shift valid every cycle; shift data only where a valid is moving in.
  always_comb begin
    v_d       = v_q;
    data_d    = data_q;
    v_d[0]    = v_i;
    data_d[0] = v_i ? data_i : data_q[0];
    for (int i = 1; i < int'(latency_p); i++) begin
      v_d[i]    = v_q[i-1];
      data_d[i] = v_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  // Pipeline state with asynchronous flush.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign v_o    = v_q[latency_p-1];
  assign data_o = data_q[latency_p-1];

endmodule

// File: rtl/bsg_nonsynth_mem_mp_sync_mask_write_byte_pipe.sv
// Multi-port, byte-masked synchronous memory with fixed read latency and a
// post-reset fill engine. Intended as a backing-store stand-in in simulation.
module bsg_nonsynth_mem_mp_sync_mask_write_byte_pipe
  import bsg_nonsynth_mem_mp_pkg::*;
#(
  parameter int unsigned width_p        = 32,
  parameter int unsigned els_p          = 1024,
  parameter int unsigned ports_p        = 2,
  parameter int unsigned read_latency_p = 1,
  parameter int unsigned init_mode_p    = 0,
  localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned mask_width_lp = width_p / 8
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  output logic                               init_done_o,
  input  logic [ports_p-1:0]                 v_i,
  input  logic [ports_p-1:0]                 w_i,
  input  logic [ports_p*addr_width_lp-1:0]   addr_i,
  input  logic [ports_p*width_p-1:0]         data_i,
  input  logic [ports_p*mask_width_lp-1:0]   w_mask_i,
  output logic [ports_p-1:0]                 ready_o,
  output logic [ports_p-1:0]                 data_v_o,
  output logic [ports_p*width_p-1:0]         data_o
);

  // Elaboration-time parameter sanity.
  if (width_p % 8 != 0) begin : g_bad_width
    $fatal(1, "width_p (%0d) must be a multiple of 8", width_p);
  end
  if (ports_p < 1) begin : g_bad_ports
    $fatal(1, "ports_p must be >= 1");
  end
  if (read_latency_p < 1) begin : g_bad_latency
    $fatal(1, "read_latency_p must be >= 1");
  end

  // Address pattern is replicated in whole-byte chunks wide enough for the address.
  localparam int unsigned chunk_lp = ((addr_width_lp + 7) / 8) * 8;
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  logic [width_p-1:0] mem_q [els_p];

  fill_state_e              state_q, state_d;
  logic [addr_width_lp-1:0] cnt_q, cnt_d;
  logic                     init_done_q, init_done_d;
  logic                     fill_we;
  logic [chunk_lp-1:0]      fill_addr_ext;
  logic [width_p-1:0]       fill_pattern;

  logic [addr_width_lp-1:0] addr_p    [ports_p];
  logic [width_p-1:0]       data_p    [ports_p];
  logic [mask_width_lp-1:0] mask_p    [ports_p];
  logic [width_p-1:0]       rd_data_p [ports_p];
  logic [ports_p-1:0]       acc, in_range, rd_v;

  // Fill engine next state: one word per cycle from address 0 until the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_we = 1'b0;
    unique case (state_q)
      e_idle, e_fill: begin
        if (init_mode_p == e_init_none) begin
          state_d = e_done;
        end else begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == last_addr_lp) ? e_done : e_fill;
        end
      end
      e_done:  state_d = e_done;
      default: state_d = e_idle;
    endcase
    init_done_d = (state_d == e_done);
  end

  // Fill engine state, counter and registered done flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Fill word for the current counter value.
  always_comb begin
    fill_addr_ext = chunk_lp'(cnt_q);
    fill_pattern  = '0;
    if (init_mode_p == e_init_addr) begin
      for (int b = 0; b < int'(width_p); b++) begin
        fill_pattern[b] = fill_addr_ext[b % int'(chunk_lp)];
      end
    end
  end

  // Per-port request decode and read sampling (reads see the pre-write array).
  always_comb begin
    for (int p = 0; p < int'(ports_p); p++) begin
      addr_p[p]    = addr_i[p*addr_width_lp +: addr_width_lp];
      data_p[p]    = data_i[p*width_p +: width_p];
      mask_p[p]    = w_mask_i[p*mask_width_lp +: mask_width_lp];
      acc[p]       = v_i[p] & init_done_q;
      in_range[p]  = (32'(addr_p[p]) < els_p);
      rd_v[p]      = acc[p] & ~w_i[p];
      rd_data_p[p] = in_range[p] ? mem_q[addr_p[p]] : 'x;
    end
  end

  // Array update: fill writes, then port writes in ascending order so the
  // highest-numbered port wins each contested byte. Not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && fill_we) begin
      mem_q[cnt_q] <= fill_pattern;
    end
    for (int p = 0; p < int'(ports_p); p++) begin
      if (acc[p]) begin
        assert (!$isunknown({w_i[p], addr_p[p]}))
          else $error("port %0d: X on w_i/addr_i of accepted request", p);
        assert (!(w_i[p] && $isunknown(mask_p[p])))
          else $error("port %0d: X on w_mask_i of accepted write", p);
        assert (in_range[p])
          else $error("port %0d: address %0d out of range", p, addr_p[p]);
        if (w_i[p] && in_range[p]) begin
          for (int k = 0; k < int'(mask_width_lp); k++) begin
            if (mask_p[p][k]) begin
              mem_q[addr_p[p]][8*k +: 8] <= data_p[p][8*k +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar p = 0; p < int'(ports_p); p++) begin : g_port
    bsg_nonsynth_mem_read_pipe #(
      .width_p  (width_p),
      .latency_p(read_latency_p)
    ) u_read_pipe (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (rd_v[p]),
      .data_i   (rd_data_p[p]),
      .v_o      (data_v_o[p]),
      .data_o   (data_o[p*width_p +: width_p])
    );
  end

  assign init_done_o = init_done_q;
  assign ready_o     = {ports_p{init_done_q}};

endmodule

// File: tb/tb_bsg_nonsynth_mem_mp_sync_mask_write_byte_pipe.sv
// Bench for the multi-port byte-masked memory: a word-array model with
// per-port read queues predicts every output each cycle; directed cases pin
// the model with literal values.
module tb_bsg_nonsynth_mem_mp_sync_mask_write_byte_pipe;

  localparam int W   = 32;
  localparam int ELS = 16;
  localparam int P   = 2;
  localparam int LAT = 3;
  localparam int AW  = 4;
  localparam int MW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           init_done;
  logic [P-1:0]   v, w, ready, dv;
  logic [P*AW-1:0] addr;
  logic [P*W-1:0] din, dout;
  logic [P*MW-1:0] mask;

  always #5 clk = ~clk;

  bsg_nonsynth_mem_mp_sync_mask_write_byte_pipe #(
    .width_p       (W),
    .els_p         (ELS),
    .ports_p       (P),
    .read_latency_p(LAT),
    .init_mode_p   (1)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .init_done_o(init_done),
    .v_i        (v),
    .w_i        (w),
    .addr_i     (addr),
    .data_i     (din),
    .w_mask_i   (mask),
    .ready_o    (ready),
    .data_v_o   (dv),
    .data_o     (dout)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  typedef struct {
    int          due;
    logic [W-1:0] data;
  } rd_t;

  logic [W-1:0] mmem [ELS];
  rd_t          rq0[$];
  rd_t          rq1[$];
  int           since = 0;
  int           cyc = 0;
  logic [P-1:0] exp_v = '0;
  logic [W-1:0] exp_d [P];

  function automatic logic [W-1:0] pat(input int a);
    return {4{a[7:0]}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    since = 0;
    rq0.delete();
    rq1.delete();
    exp_v = '0;
    for (int p = 0; p < P; p++) exp_d[p] = '0;
  endtask

  // Apply one clock edge's worth of architectural behaviour.
  task automatic model_edge();
    bit  done_before;
    rd_t e;
    int  a;
    if (!rst_n) return;
    cyc++;
    done_before = (since >= ELS);
    if (done_before) begin
      for (int p = 0; p < P; p++) begin
        if (v[p] && !w[p]) begin
          a      = int'(addr[p*AW +: AW]);
          e.due  = cyc + LAT - 1;
          e.data = mmem[a];
          if (p == 0) rq0.push_back(e);
          else        rq1.push_back(e);
        end
      end
      for (int p = 0; p < P; p++) begin
        if (v[p] && w[p]) begin
          a = int'(addr[p*AW +: AW]);
          for (int k = 0; k < MW; k++)
            if (mask[p*MW + k]) mmem[a][8*k +: 8] = din[p*W + 8*k +: 8];
        end
      end
    end
    exp_v = '0;
    if (rq0.size() != 0 && rq0[0].due == cyc) begin
      exp_v[0] = 1'b1;
      exp_d[0] = rq0.pop_front().data;
    end
    if (rq1.size() != 0 && rq1[0].due == cyc) begin
      exp_v[1] = 1'b1;
      exp_d[1] = rq1.pop_front().data;
    end
    if (since < ELS) begin
      since++;
      if (since == ELS)
        for (int i = 0; i < ELS; i++) mmem[i] = pat(i);
    end
  endtask

  task automatic compare();
    logic exp_done;
    exp_done = rst_n && (since >= ELS);
    chk("init_done", 64'(init_done), 64'(exp_done));
    chk("ready", 64'(ready), 64'({P{exp_done}}));
    for (int p = 0; p < P; p++) begin
      chk($sformatf("data_v[%0d]", p), 64'(dv[p]), 64'(exp_v[p]));
      chk($sformatf("data[%0d]", p), 64'(dout[p*W +: W]), 64'(exp_d[p]));
    end
  endtask

  // One cycle: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    v = '0; w = '0; addr = '0; din = '0; mask = '0;
  endtask

  task automatic set_req(input int p, input bit vv, input bit ww, input int a,
                         input logic [W-1:0] d, input logic [MW-1:0] m);
    v[p]                = vv;
    w[p]                = ww;
    addr[p*AW +: AW]    = a[AW-1:0];
    din[p*W +: W]       = d;
    mask[p*MW +: MW]    = m;
  endtask

  task automatic read_lit(input int p, input int a, input logic [W-1:0] expv,
                          input string name);
    idle();
    set_req(p, 1, 0, a, '0, '0);
    step();
    idle();
    repeat (LAT - 1) step();
    chk({name, "_v"}, 64'(dv[p]), 64'd1);
    chk(name, 64'(dout[p*W +: W]), 64'(expv));
  endtask

  task automatic fill_window(input string name);
    for (int i = 0; i < ELS - 1; i++) begin
      step();
      chk({name, "_low"}, 64'(init_done), 64'd0);
    end
    step();
    chk({name, "_rise"}, 64'(init_done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (3) step();

    // Fill timing and address pattern.
    rst_n = 1'b1;
    fill_window("fill");
    read_lit(0, 5, 32'h0505_0505, "fill_addr5");
    read_lit(1, 15, 32'h0F0F_0F0F, "fill_addr15");

    // Byte merge from two ports.
    idle();
    set_req(0, 1, 1, 3, 32'hAABB_CCDD, 4'b0011);
    set_req(1, 1, 1, 3, 32'h1122_3344, 4'b1100);
    step();
    read_lit(0, 3, 32'h1122_CCDD, "merge");

    // Full-word conflict: highest port wins.
    idle();
    set_req(0, 1, 1, 7, 32'h1, 4'hF);
    set_req(1, 1, 1, 7, 32'h2, 4'hF);
    step();
    read_lit(1, 7, 32'h2, "conflict");

    // Read during write returns old data.
    idle();
    set_req(0, 1, 1, 2, 32'h0, 4'hF);
    step();
    idle();
    set_req(0, 1, 0, 2, '0, '0);
    set_req(1, 1, 1, 2, 32'hDEAD_BEEF, 4'hF);
    step();
    idle();
    repeat (LAT - 1) step();
    chk("rdw_old_v", 64'(dv[0]), 64'd1);
    chk("rdw_old", 64'(dout[31:0]), 64'd0);
    read_lit(0, 2, 32'hDEAD_BEEF, "rdw_new");

    // Back-to-back reads on port 1, then data holds.
    idle();
    set_req(1, 1, 0, 1, '0, '0);
    step();
    set_req(1, 1, 0, 4, '0, '0);
    step();
    set_req(1, 1, 0, 9, '0, '0);
    step();
    idle();
    chk("b2b_0", 64'({dv[1], dout[63:32]}), {31'd0, 1'b1, 32'h0101_0101});
    step();
    chk("b2b_1", 64'({dv[1], dout[63:32]}), {31'd0, 1'b1, 32'h0404_0404});
    step();
    chk("b2b_2", 64'({dv[1], dout[63:32]}), {31'd0, 1'b1, 32'h0909_0909});
    step();
    chk("b2b_hold", 64'({dv[1], dout[63:32]}), {31'd0, 1'b0, 32'h0909_0909});

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < P; p++)
        set_req(p, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, ELS - 1)), $urandom, MW'($urandom));
      step();
    end
    idle();
    repeat (LAT) step();

    // Reset in the middle of a fill.
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    fill_window("refill");
    for (int a = 0; a < ELS; a++) read_lit(a % 2, a, pat(a), $sformatf("refill_addr%0d", a));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
